axis_psk_frame_gen: RTL and testbench

Transmit-side AXI-Stream frame builder, and the writer of the 8-bit frame buffer FIFO.
- On a start request it emits one framed byte stream: preamble, sync word, length byte, payload bytes pulled from an upstream AXI-Stream byte source, and a CRC-8 trailer.
- It marks the first beat with tuser and the last beat with tlast.
- All state advances only on cycles where s_axis_aclken is high, the 1.024 MHz symbol-rate enable shared with the FIFO.

---
 rtl/axis_psk_frame_pkg.sv | 41 ++++
 rtl/axis_psk_frame_gen.sv | 212 +++++++++++++++++++++
 tb/tb_axis_psk_frame_gen.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_psk_frame_pkg.sv
// ---------------------------------------------------------------------------
// axis_psk_frame_pkg
// Shared definitions for the transmit-side PSK frame builder:
//   - frame_state_e : frame builder FSM states
//   - DEF_*         : default preamble byte, sync word, CRC polynomial/init
//   - crc8_byte()   : one-byte CRC-8 update, MSB-first, no reflection
// ---------------------------------------------------------------------------
package axis_psk_frame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SYNC = 3'd2,
    LEN  = 3'd3,
    PAY  = 3'd4,
    CRC  = 3'd5
  } frame_state_e;

  localparam logic [7:0]  DEF_PREAMBLE_BYTE = 8'h55;
  localparam logic [15:0] DEF_SYNC_WORD     = 16'hD391;
  localparam logic [7:0]  DEF_CRC_POLY      = 8'h07;
  localparam logic [7:0]  DEF_CRC_INIT      = 8'h00;

  // Byte-wide CRC-8 step: the data byte is folded into the register first,
  // then eight shift/conditional-XOR steps are applied MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ poly;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_psk_frame_gen.sv
// ---------------------------------------------------------------------------
// axis_psk_frame_gen
// Builds one framed byte stream per start request and writes it to the frame
// buffer FIFO over AXI-Stream:
//   preamble (PREAMBLE_LEN x PREAMBLE_BYTE), sync word (MSB byte first),
//   length byte, len payload bytes pulled from upstream, CRC-8 trailer.
// The CRC covers the length byte and the payload bytes.
//
// Ports:
//   s_axis_aclk / s_axis_areset : clock, asynchronous active-high reset
//   s_axis_aclken               : symbol-rate enable; all state and
//                                 handshakes advance only when high
//   start / length              : frame request and payload byte count
//   busy / done                 : frame in progress / CRC beat transferred
//   s_axis_t{data,valid,ready}  : upstream payload byte source
//   m_axis_t{data,valid,ready,last,user} : frame bytes to the FIFO
//                                 (tuser = first preamble beat, tlast = CRC)
// ---------------------------------------------------------------------------
module axis_psk_frame_gen
  import axis_psk_frame_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN  = 32'd4,
  parameter logic [7:0]  PREAMBLE_BYTE = DEF_PREAMBLE_BYTE,
  parameter logic [15:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter logic [7:0]  CRC_POLY      = DEF_CRC_POLY,
  parameter logic [7:0]  CRC_INIT      = DEF_CRC_INIT
) (
  input  logic       s_axis_aclk,
  input  logic       s_axis_areset,
  input  logic       s_axis_aclken,
  input  logic       start,
  input  logic [7:0] length,
  output logic       busy,
  output logic       done,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
);

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 32'd1);

  frame_state_e state_r, state_nxt_s;
  logic [3:0]   beat_cnt_r, beat_cnt_nxt_s;
  logic [7:0]   pay_cnt_r, pay_cnt_nxt_s;
  logic [7:0]   len_r, len_nxt_s;
  logic [7:0]   crc_r, crc_nxt_s;
  logic         xfer_s;

  // Beat presentation decoded from the registered state; PAY passes upstream through.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    done          = 1'b0;
    case (state_r)
      IDLE: begin
        m_axis_tvalid = 1'b0;
      end
      PRE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = PREAMBLE_BYTE;
        m_axis_tuser  = (beat_cnt_r == 4'd0);
      end
      SYNC: begin
        m_axis_tvalid = 1'b1;
        if (beat_cnt_r == 4'd0) begin
          m_axis_tdata = SYNC_WORD[15:8];
        end else begin
          m_axis_tdata = SYNC_WORD[7:0];
        end
      end
      LEN: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = len_r;
      end
      PAY: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        s_axis_tready = m_axis_tready;
      end
      CRC: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = crc_r;
        m_axis_tlast  = 1'b1;
        // tvalid is known high here, so the transfer reduces to ready & enable.
        done          = m_axis_tready & s_axis_aclken;
      end
      default: begin
        m_axis_tvalid = 1'b0;
      end
    endcase
  end

  assign busy   = (state_r != IDLE);
  // In PAY the output beat and the payload accept are the same handshake.
  assign xfer_s = m_axis_tvalid & m_axis_tready & s_axis_aclken;

  // Next-state, counter and CRC computation; every advance is gated by an enabled handshake.
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    pay_cnt_nxt_s  = pay_cnt_r;
    len_nxt_s      = len_r;
    crc_nxt_s      = crc_r;
    case (state_r)
      IDLE: begin
        if (start && s_axis_aclken) begin
          len_nxt_s      = length;
          crc_nxt_s      = CRC_INIT;
          beat_cnt_nxt_s = 4'd0;
          pay_cnt_nxt_s  = 8'd0;
          state_nxt_s    = PRE;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      PRE: begin
        if (xfer_s) begin
          if (beat_cnt_r == PRE_LAST) begin
            beat_cnt_nxt_s = 4'd0;
            state_nxt_s    = SYNC;
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + 4'd1;
          end
        end else begin
          state_nxt_s = PRE;
        end
      end
      SYNC: begin
        if (xfer_s) begin
          if (beat_cnt_r == 4'd1) begin
            beat_cnt_nxt_s = 4'd0;
            state_nxt_s    = LEN;
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + 4'd1;
          end
        end else begin
          state_nxt_s = SYNC;
        end
      end
      LEN: begin
        if (xfer_s) begin
          crc_nxt_s = crc8_byte(crc_r, len_r, CRC_POLY);
          // A zero-length frame skips straight to the trailer.
          if (len_r != 8'd0) begin
            pay_cnt_nxt_s = 8'd0;
            state_nxt_s   = PAY;
          end else begin
            state_nxt_s   = CRC;
          end
        end else begin
          state_nxt_s = LEN;
        end
      end
      PAY: begin
        if (xfer_s) begin
          crc_nxt_s     = crc8_byte(crc_r, s_axis_tdata, CRC_POLY);
          pay_cnt_nxt_s = pay_cnt_r + 8'd1;
          // Compare against len-1 so a 255-byte payload never wraps the counter.
          if (pay_cnt_r == (len_r - 8'd1)) begin
            state_nxt_s = CRC;
          end else begin
            state_nxt_s = PAY;
          end
        end else begin
          state_nxt_s = PAY;
        end
      end
      CRC: begin
        if (xfer_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CRC;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; held whenever the symbol-rate enable is low.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_r    <= IDLE;
      beat_cnt_r <= 4'd0;
      pay_cnt_r  <= 8'd0;
      len_r      <= 8'd0;
      crc_r      <= CRC_INIT;
    end else if (s_axis_aclken) begin
      state_r    <= state_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      pay_cnt_r  <= pay_cnt_nxt_s;
      len_r      <= len_nxt_s;
      crc_r      <= crc_nxt_s;
    end else begin
      state_r    <= state_r;
      beat_cnt_r <= beat_cnt_r;
      pay_cnt_r  <= pay_cnt_r;
      len_r      <= len_r;
      crc_r      <= crc_r;
    end
  end

endmodule

// File: tb/tb_axis_psk_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_axis_psk_frame_gen
// Directed self-checking bench for axis_psk_frame_gen. A driver process
// supplies the enable pattern, downstream ready and the upstream payload
// source; a monitor process records transferred beats at the falling edge.
// The main initial block runs the directed steps and compares against
// hand-written frames (or a bit-serial CRC model for long frames).
// ---------------------------------------------------------------------------
module tb_axis_psk_frame_gen;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       aclken = 1'b1;
  logic       start  = 1'b0;
  logic [7:0] length = 8'h00;
  logic       busy, done;
  logic [7:0] s_tdata  = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       m_tlast, m_tuser;

  axis_psk_frame_gen dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_aclken (aclken),
    .start         (start),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int  ce_div      = 1;
  bit  rand_ready  = 1'b0;
  int  gap_idx     = -1;
  int  gap_len     = 0;
  int  gap_seen    = 0;
  int  gap_viol    = 0;
  bit  gap_active  = 1'b0;
  bit  hold_chk    = 1'b0;
  int  hold_viol   = 0;
  int  done_cnt    = 0;
  int  done_off_ce = 0;
  int  sready_seen = 0;
  int  src_sent    = 0;
  bit  s_acc_seen  = 1'b0;
  bit  prev_ce     = 1'b1;
  logic [11:0] prev_outs = 12'h000;

  logic [7:0] src_q[$];
  logic [7:0] cap_d[$];
  bit         cap_u[$];
  bit         cap_l[$];

  // Driver: enable, ready and upstream source, updated 1 ns after each rising edge.
  initial begin : drive_proc
    int ce_cnt;
    ce_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (s_acc_seen) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        src_sent++;
        s_acc_seen = 1'b0;
      end
      ce_cnt++;
      aclken     = ((ce_cnt % ce_div) == 0);
      m_tready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      gap_active = (gap_idx >= 0) && (src_sent == gap_idx) && (gap_seen < gap_len);
      s_tvalid   = (src_q.size() > 0) && !gap_active;
      s_tdata    = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  // Monitor: records transfers and side observations at the falling edge.
  initial begin : mon_proc
    forever begin
      @(negedge clk);
      if (rst) begin
        s_acc_seen = 1'b0;
        prev_ce    = 1'b1;
      end else begin
        s_acc_seen = s_tvalid & s_tready & aclken;
        if (m_tvalid & m_tready & aclken) begin
          cap_d.push_back(m_tdata);
          cap_u.push_back(m_tuser);
          cap_l.push_back(m_tlast);
        end
        if (done) begin
          done_cnt++;
          if (!aclken) done_off_ce++;
        end
        if (s_tready) sready_seen++;
        if (gap_active && aclken) begin
          gap_seen++;
          if (m_tvalid) gap_viol++;
        end
        if (hold_chk && !prev_ce && ({busy, m_tvalid, m_tdata, m_tuser, m_tlast} !== prev_outs))
          hold_viol++;
        prev_outs = {busy, m_tvalid, m_tdata, m_tuser, m_tlast};
        prev_ce   = aclken;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC-8 (poly 0x07, init 0x00) over length byte and payload.
  function automatic logic [7:0] ref_crc(input logic [7:0] b[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (b[k]) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ b[k][i];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic model_frame(input logic [7:0] n, input logic [7:0] pay[$], output logic [7:0] exp[$]);
    logic [7:0] crc_in[$];
    exp.delete();
    for (int i = 0; i < 4; i++) exp.push_back(8'h55);
    exp.push_back(8'hD3);
    exp.push_back(8'h91);
    exp.push_back(n);
    crc_in.push_back(n);
    foreach (pay[i]) begin
      exp.push_back(pay[i]);
      crc_in.push_back(pay[i]);
    end
    exp.push_back(ref_crc(crc_in));
  endtask

  task automatic start_frame(input logic [7:0] n);
    int guard;
    guard  = 0;
    start  = 1'b1;
    length = n;
    do begin
      @(negedge clk);
      guard++;
    end while (!aclken && guard < 200);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] n, input logic [7:0] pay[$], input int limit);
    int d0;
    int cyc;
    cap_d.delete();
    cap_u.delete();
    cap_l.delete();
    src_q       = pay;
    src_sent    = 0;
    sready_seen = 0;
    d0          = done_cnt;
    start_frame(n);
    cyc = 0;
    while (done_cnt < d0 + 1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_finished"}, 32'(done_cnt >= d0 + 1), 32'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp[$]);
    int nu;
    int nl;
    nu = 0;
    nl = 0;
    chk({tag, "_beats"}, 32'(cap_d.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < cap_d.size()) chk($sformatf("%s_beat%0d", tag, i), 32'(cap_d[i]), 32'(exp[i]));
    end
    foreach (cap_u[i]) begin
      if (cap_u[i]) nu++;
      if (cap_l[i]) nl++;
    end
    chk({tag, "_tuser_count"}, 32'(nu), 32'd1);
    chk({tag, "_tlast_count"}, 32'(nl), 32'd1);
    if (cap_d.size() > 0) begin
      chk({tag, "_tuser_first"}, 32'(cap_u[0]), 32'd1);
      chk({tag, "_tlast_final"}, 32'(cap_l[cap_l.size() - 1]), 32'd1);
    end
  endtask

  initial begin : main_proc
    logic [7:0] pay[$];
    logic [7:0] exp[$];
    logic [7:0] t1_exp[$];
    int guard;

    t1_exp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h03, 8'h01, 8'h02, 8'h03, 8'h72};

    // Reset: every output reads zero.
    #1 rst = 1'b1;
    #1;
    chk("reset_outputs", 32'({busy, done, m_tvalid, m_tdata, m_tlast, m_tuser, s_tready}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: length 3, payload 01 02 03, full rate.
    pay = '{8'h01, 8'h02, 8'h03};
    run_frame("t1", 8'd3, pay, 200);
    check_frame("t1", t1_exp);

    // Test 2: zero-length frame, CRC of a single 0x00 byte is 0x00.
    pay.delete();
    exp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hD3, 8'h91, 8'h00, 8'h00};
    run_frame("t2", 8'd0, pay, 200);
    check_frame("t2", exp);
    chk("t2_sready_never", 32'(sready_seen), 32'd0);

    // Test 3: enable 1 cycle in 32 with random ready toggling.
    ce_div      = 32;
    rand_ready  = 1'b1;
    hold_chk    = 1'b1;
    hold_viol   = 0;
    done_off_ce = 0;
    pay = '{8'h01, 8'h02, 8'h03};
    run_frame("t3", 8'd3, pay, 8000);
    check_frame("t3", t1_exp);
    chk("t3_hold_when_disabled", 32'(hold_viol), 32'd0);
    chk("t3_done_only_enabled", 32'(done_off_ce), 32'd0);
    hold_chk   = 1'b0;
    rand_ready = 1'b0;
    ce_div     = 1;
    repeat (2) @(negedge clk);

    // Test 4: upstream stall of 5 enabled cycles before byte 02.
    gap_seen = 0;
    gap_viol = 0;
    gap_len  = 5;
    gap_idx  = 1;
    pay = '{8'h01, 8'h02, 8'h03};
    run_frame("t4", 8'd3, pay, 300);
    check_frame("t4", t1_exp);
    chk("t4_gap_cycles", 32'(gap_seen), 32'd5);
    chk("t4_tvalid_low_in_gap", 32'(gap_viol), 32'd0);
    gap_idx = -1;
    gap_len = 0;

    // Test 5: restart request during PAY is ignored, then reset mid-payload.
    cap_d.delete();
    cap_u.delete();
    cap_l.delete();
    src_q    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    src_sent = 0;
    start_frame(8'd5);
    guard = 0;
    while (!s_tready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("t5_reached_payload", 32'(s_tready), 32'd1);
    @(posedge clk);
    #2;
    start  = 1'b1;
    length = 8'd9;
    @(posedge clk);
    #2;
    start = 1'b0;
    @(negedge clk);
    chk("t5_restart_ignored_tuser", 32'(m_tuser), 32'd0);
    chk("t5_restart_ignored_data", 32'(m_tdata), 32'h33);
    chk("t5_still_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_reset_outputs", 32'({busy, done, m_tvalid, m_tdata, m_tlast, m_tuser, s_tready}), 32'd0);
    repeat (2) @(negedge clk);
    src_q.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pay = '{8'hA5, 8'h5A};
    model_frame(8'd2, pay, exp);
    run_frame("t5", 8'd2, pay, 200);
    check_frame("t5", exp);

    // Test 6: maximum length 255 with payload 00..FE.
    pay.delete();
    for (int i = 0; i < 255; i++) pay.push_back(8'(i));
    model_frame(8'd255, pay, exp);
    run_frame("t6", 8'd255, pay, 1000);
    check_frame("t6", exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
